signed_op_sequencer: RTL and testbench

- Multi-cycle controller that accepts two sign-magnitude operands and an add/subtract opcode.
- Routes the operands one at a time through a single shared sign-magnitude-to-two's-complement converter, instanced inside this block.
- Performs the signed add or subtract, then returns the result as both two's complement and sign-magnitude.
- Sits between the operand-entry logic and the display/readout path of the calculator datapath.

---
 rtl/signed_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_signed_op_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/signed_op_sequencer.sv
// Multi-cycle signed add/subtract of two sign-magnitude operands through one
// shared sign-magnitude to two's-complement converter; result in both forms.

module sm_to_tc #(
  parameter int bits = 8
) (
  input  logic             sign,
  input  logic [bits-1:0]  mag,
  output logic [bits:0]    tc
);
  // Negative zero falls out as +0: -(0) == 0.
  always_comb begin
    tc = {1'b0, mag};
    if (sign) tc = ~{1'b0, mag} + 1'b1;
  end
endmodule

module signed_op_sequencer #(
  parameter int bits = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [bits-1:0]        magA,
  input  logic                   signA,
  input  logic [bits-1:0]        magB,
  input  logic                   signB,
  input  logic                   sub,
  output logic                   busy,
  output logic                   done,
  output logic signed [bits+1:0] result,
  output logic                   resultSign,
  output logic [bits:0]          resultMag
);
  localparam int RW = bits + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_A = 3'd1,
    CONV_B = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [bits-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic            sub_q, sub_d;
  logic [bits:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [RW-1:0]   result_q, result_d;
  logic            result_sign_q, result_sign_d;
  logic [bits:0]   result_mag_q, result_mag_d;
  logic            done_q, done_d;

  logic            latch_en, load_a, load_b, exec_en, sel_b;
  logic            conv_sign;
  logic [bits-1:0] conv_mag;
  logic [bits:0]   conv_out;
  logic [RW-1:0]   ext_a, ext_b, sum;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV_A;
      CONV_A:  state_d = CONV_B;
      CONV_B:  state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: state decodes; the converter mux select comes only from here
  always_comb begin
    busy     = (state_q != IDLE);
    latch_en = (state_q == IDLE) && start;
    load_a   = (state_q == CONV_A);
    load_b   = (state_q == CONV_B);
    exec_en  = (state_q == EXEC);
    sel_b    = (state_q == CONV_B);
  end

  assign conv_sign = sel_b ? sign_b_q : sign_a_q;
  assign conv_mag  = sel_b ? mag_b_q  : mag_a_q;

  sm_to_tc #(.bits(bits)) u_conv (
    .sign (conv_sign),
    .mag  (conv_mag),
    .tc   (conv_out)
  );

  assign ext_a = {op_a_q[bits], op_a_q};
  assign ext_b = {op_b_q[bits], op_b_q};
  assign sum   = sub_q ? (ext_a - ext_b) : (ext_a + ext_b);

  always_comb begin
    mag_a_d       = mag_a_q;
    sign_a_d      = sign_a_q;
    mag_b_d       = mag_b_q;
    sign_b_d      = sign_b_q;
    sub_d         = sub_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    result_d      = result_q;
    result_sign_d = result_sign_q;
    result_mag_d  = result_mag_q;
    done_d        = 1'b0;
    if (latch_en) begin
      mag_a_d  = magA;
      sign_a_d = signA;
      mag_b_d  = magB;
      sign_b_d = signB;
      sub_d    = sub;
    end
    if (load_a) op_a_d = conv_out;
    if (load_b) op_b_d = conv_out;
    if (exec_en) begin
      result_d      = sum;
      result_sign_d = sum[RW-1];
      // |sum| always fits in bits+1, so negating only the low bits is exact
      result_mag_d  = sum[RW-1] ? (~sum[bits:0] + 1'b1) : sum[bits:0];
      done_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a_q       <= '0;
      sign_a_q      <= 1'b0;
      mag_b_q       <= '0;
      sign_b_q      <= 1'b0;
      sub_q         <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      result_q      <= '0;
      result_sign_q <= 1'b0;
      result_mag_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      mag_a_q       <= mag_a_d;
      sign_a_q      <= sign_a_d;
      mag_b_q       <= mag_b_d;
      sign_b_q      <= sign_b_d;
      sub_q         <= sub_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      result_q      <= result_d;
      result_sign_q <= result_sign_d;
      result_mag_q  <= result_mag_d;
      done_q        <= done_d;
    end
  end

  assign done       = done_q;
  assign result     = result_q;
  assign resultSign = result_sign_q;
  assign resultMag  = result_mag_q;

endmodule

// File: tb/tb_signed_op_sequencer.sv
// Randomized bench for signed_op_sequencer against an integer-arithmetic model.

module tb_signed_op_sequencer;
  localparam int BITS = 8;

  logic                   clk, rst, start;
  logic [BITS-1:0]        magA, magB;
  logic                   signA, signB, sub;
  logic                   busy, done;
  logic signed [BITS+1:0] result;
  logic                   resultSign;
  logic [BITS:0]          resultMag;

  int n_tests = 0;
  int n_fail  = 0;

  signed_op_sequencer #(.bits(BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .magA       (magA),
    .signA      (signA),
    .magB       (magB),
    .signB      (signB),
    .sub        (sub),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .resultSign (resultSign),
    .resultMag  (resultMag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_res"},  int'(result), 0);
    chk({tag, "_sign"}, int'(resultSign), 0);
    chk({tag, "_mag"},  int'(resultMag), 0);
  endtask

  // One operation; start is sampled at the next edge (k). With noisy set, the
  // inputs are scrambled and start is pulsed at random while the op is in flight.
  task automatic run_op(input logic [BITS-1:0] ma, input logic sa,
                        input logic [BITS-1:0] mb, input logic sb,
                        input logic s, input bit noisy);
    int a, b, r, m;
    a = sa ? -int'(ma) : int'(ma);
    b = sb ? -int'(mb) : int'(mb);
    r = s ? a - b : a + b;
    m = (r < 0) ? -r : r;
    magA = ma; signA = sa; magB = mb; signB = sb; sub = s; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_k", int'(busy), 1);
    chk("done_k", int'(done), 0);
    for (int i = 1; i <= 3; i++) begin
      if (noisy) begin
        magA  = BITS'($urandom);
        magB  = BITS'($urandom);
        signA = 1'($urandom);
        signB = 1'($urandom);
        sub   = 1'($urandom);
        start = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      chk("done_lat", int'(done), int'(i == 3));
      chk("busy_lat", int'(busy), 1);
    end
    start = 1'b0;
    chk("result", int'(result), r);
    chk("sign",   int'(resultSign), int'(r < 0));
    chk("mag",    int'(resultMag), m);
    @(posedge clk); #1;
    chk("done_clr", int'(done), 0);
    chk("busy_clr", int'(busy), 0);
    chk("hold_res", int'(result), r);
    chk("hold_mag", int'(resultMag), m);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    magA = '0; magB = '0; signA = 1'b0; signB = 1'b0; sub = 1'b0;
    #2;
    chk_zero("reset");
    #20 rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("idle");

    // directed cases
    run_op(8'd5,   1'b0, 8'd3,   1'b0, 1'b0, 1'b0);  // +8
    run_op(8'd5,   1'b1, 8'd3,   1'b0, 1'b1, 1'b0);  // -8
    run_op(8'd255, 1'b1, 8'd255, 1'b0, 1'b1, 1'b0);  // -510
    run_op(8'd255, 1'b0, 8'd255, 1'b1, 1'b1, 1'b0);  // +510
    run_op(8'd0,   1'b1, 8'd0,   1'b1, 1'b0, 1'b0);  // -0 + -0
    run_op(8'd7,   1'b0, 8'd7,   1'b0, 1'b1, 1'b0);  // 7 - 7
    run_op(8'd0,   1'b1, 8'd9,   1'b1, 1'b1, 1'b0);  // -0 - -9 = +9
    // start pulses while busy are ignored; inputs after the start edge don't matter
    run_op(8'd100, 1'b1, 8'd27,  1'b1, 1'b0, 1'b1);  // -127

    // back-to-back: start raised in the first idle cycle is accepted
    for (int i = 0; i < 40; i++)
      run_op(BITS'($urandom), 1'($urandom), BITS'($urandom), 1'($urandom),
             1'($urandom), bit'($urandom));

    // result stays put in idle
    run_op(8'd200, 1'b0, 8'd13, 1'b1, 1'b0, 1'b0);  // +187
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", int'(result), 187);

    // async reset during CONV_B
    magA = 8'd40; signA = 1'b0; magB = 8'd2; signB = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;   // now CONV_A
    @(posedge clk); #3 rst = 1'b1;     // now CONV_B
    #1;
    chk_zero("rst_mid");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_nodone", int'(done), 0);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_rel");
    run_op(8'd40, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);    // +38

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
